instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the instruction-memory read interface. Holds the fetch PC and
//  drives the byte address into the combinational, little-endian, byte-addressed
//  instruction memory. Captures each 32-bit word with its PC in a small prefetch FIFO.
//  Presents entries to decode over a valid/ready handshake; a redirect from execute flushes the FIFO.
// PARAMETERS
//  RESET_PC    32'h0000_0000  fetch PC loaded on reset
//  FIFO_DEPTH  2              prefetch entries; power of two, >= 2
// PORTS
//  clk             in   1   single clock, all state on rising edge
//  rst             in   1   synchronous reset, active-high
//  imem_addr       out  32  byte address to instruction memory (= fetch_pc, combinational)
//  imem_rdata      in   32  instruction word, valid same cycle as imem_addr
//  redirect_valid  in   1   branch/jump/trap redirect request
//  redirect_pc     in   32  redirect target
//  if_valid        out  1   FIFO head valid toward decode
//  if_ready        in   1   decode accepts head this cycle
//  if_instr        out  32  head instruction word
//  if_pc           out  32  head PC
//  if_fault        out  1   misaligned-fetch fault (see CONFIGURATION)
// BEHAVIOUR
//  - Interface: one clock; reset is synchronous and active-high.
//  - Reset: fetch_pc=RESET_PC, FIFO empty, state=S_RUN. Outputs: if_valid=0,
//    if_instr=0, if_pc=0, if_fault=0, imem_addr=RESET_PC.
//  - pop  = if_valid & if_ready.
//  - push = (state==S_RUN) & (!full | pop) & !redirect_valid.
//  - On push: enqueue {fetch_pc, imem_rdata}; fetch_pc <= fetch_pc+4, modulo 2^32
//    (32'hFFFF_FFFC wraps to 0).
//  - Full without pop: no push, fetch_pc holds.
//  - Throughput 1 instr/cycle; push+pop when full is legal, count unchanged.
//  - if_valid = !empty. if_instr/if_pc are registered FIFO head, stable while
//    if_valid & !if_ready.
//  - Latency: first entry visible the cycle after reset deasserts. Redirect
//    asserted in cycle N gives if_valid with if_pc=redirect_pc in cycle N+2.
//  - Redirect priority:
//    - Redirect overrides push and pop. FIFO is cleared and fetch_pc <= redirect_pc.
//    - Head offered in a redirect cycle is discarded even if if_ready=1.
//    - Redirect in consecutive cycles: last target wins.
//  - States:
//    - S_RUN: normal fetch.
//    - S_FAULT: no push, FIFO drains normally; exit only via redirect or rst.
//  - Reset mid-stream dominates redirect and handshake; FIFO flushed same edge.
//  - Entry count tracked with ptr width $clog2(FIFO_DEPTH)+1; full = count==FIFO_DEPTH.
// CONFIGURATION
//  IFU_MISALIGN_TRAP_EN defined:
//    - A push with fetch_pc[1:0]!=0 enqueues an entry marked faulted and enters S_FAULT.
//    - When that entry is head, if_fault=1 with if_valid=1.
//    - A redirect returns the state to S_RUN.
//  IFU_MISALIGN_TRAP_EN undefined:
//    - fetch_pc[1:0] is forced to 0 on reset load and redirect load.
//    - if_fault tied 0; S_FAULT unreachable.
// STRUCTURE
//  Package ifu_pkg:
//    - typedef fetch_entry_t {pc[31:0], instr[31:0], fault}
//    - enum ifu_state_t {S_RUN, S_FAULT}
//    - INSTR_NOP = 32'h0000_0013
//  Sub-module fetch_fifo: parameterised sync FIFO of fetch_entry_t, with push,
//    pop, flush, full, empty, head. Flush has priority over push/pop.
// TESTING
//  1 Reset, mem[0..]=0x13,0x00100093, if_ready=1 -> pc 0,4,8 on consecutive
//    cycles; first if_valid one cycle after rst drops.
//  2 if_ready=0 for 5 cycles -> FIFO fills to 2; imem_addr holds at 8;
//    if_pc stays 0; release -> pcs 0,4,8 with no gap.
//  3 redirect_valid, redirect_pc=0x100 while head pc=4, if_ready=1 -> pc 4 not
//    consumed; two cycles later if_pc=0x100, then 0x104.
//  4 Redirect to 0xFFFF_FFF8 -> if_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
//  5 IFU_MISALIGN_TRAP_EN: redirect to 0x102 -> if_valid=1, if_fault=1,
//    if_pc=0x102; no further push; redirect 0x200 -> normal fetch, if_fault=0.
//  6 rst pulsed while FIFO full and redirect asserted -> next cycle if_valid=0,
//    imem_addr=RESET_PC.

Source files
------------

// File: rtl/ifu_pkg.sv
// Purpose : shared types for the instruction fetch unit (fetch entry, FSM state).
// Latency : n/a (types and constants only).
// Backpres: n/a.
// Optional feature macro used by importers: IFU_MISALIGN_TRAP_EN.
package ifu_pkg;

  // One prefetched instruction with the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FAULT = 1'b1
  } ifu_state_t;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Purpose : synchronous FIFO of fetch_entry_t holding prefetched instructions.
// Latency : a push is visible at head the cycle after it is written.
// Backpres: caller must not push when full unless popping; flush beats push/pop.
// Ports   : clk, rst (sync, active-high), flush, push/push_data, pop,
//           full, empty, head (registered storage at the read pointer).
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] count;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count = wr_ptr - rd_ptr;
  assign full  = (count == PTR_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Purpose : drives the fetch PC into instruction memory and prefetches words into a FIFO for decode.
// Latency : first entry the cycle after reset drops; redirect in cycle N shows its target in N+2.
// Backpres: if_valid/if_ready handshake; fetch stalls (PC holds) while the FIFO is full and not popping.
// Ports   : clk, rst (sync, active-high); imem_addr/imem_rdata to instruction memory;
//           redirect_valid/redirect_pc from execute; if_valid/if_ready/if_instr/if_pc/if_fault to decode.
// Config  : define IFU_MISALIGN_TRAP_EN to trap misaligned fetch PCs instead of forcing alignment.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        if_fault
);

`ifdef IFU_MISALIGN_TRAP_EN
  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFF;
  localparam logic        FAULT_EN = 1'b1;
`else
  // Without the trap, loaded PCs are forced word-aligned so faults cannot arise.
  localparam logic [31:0] PC_MASK  = 32'hFFFF_FFFC;
  localparam logic        FAULT_EN = 1'b0;
`endif

  ifu_state_t   state, state_nxt;
  logic [31:0]  fetch_pc;
  logic         fifo_full, fifo_empty;
  logic         hs_pop, push, pop;
  fetch_entry_t push_entry, head;

  assign imem_addr = fetch_pc;
  assign if_valid  = !fifo_empty;

  // A redirect flushes the FIFO, so it blocks both the push and the pop.
  assign hs_pop = if_valid & if_ready;
  assign pop    = hs_pop & !redirect_valid;
  assign push   = (state == S_RUN) & (!fifo_full | hs_pop) & !redirect_valid;

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = fetch_pc;
    push_entry.instr = imem_rdata;
`ifdef IFU_MISALIGN_TRAP_EN
    push_entry.fault = (fetch_pc[1:0] != 2'b00);
`endif
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      state_nxt = S_RUN;
    end
`ifdef IFU_MISALIGN_TRAP_EN
    else if (push && push_entry.fault) begin
      state_nxt = S_FAULT;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      fetch_pc <= RESET_PC & PC_MASK;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & PC_MASK;
      end else if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  // Payload reads as zero while nothing is offered, matching the reset view.
  assign if_instr = if_valid ? head.instr : 32'd0;
  assign if_pc    = if_valid ? head.pc    : 32'd0;
  assign if_fault = if_valid & head.fault & FAULT_EN;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_fault;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_fault       (if_fault)
  );

  // Byte-addressed memory image: words 0 and 4 hold 0x13 and 0x00100093,
  // everything else is a fixed hash of the address.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd4:   return 8'h93;
      32'd6:   return 8'h10;
      32'd1, 32'd2, 32'd3, 32'd5, 32'd7: return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  assign imem_rdata = imem_word(imem_addr);

  function automatic logic [31:0] align(input logic [31:0] a);
    return TRAP ? a : (a & 32'hFFFF_FFFC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of fetched entries, a fetch PC and a fault latch.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ment_t;

  ment_t       q[$];
  logic [31:0] mpc;
  bit          mfault;
  bit          model_ok = 1'b0;

  always @(posedge clk) begin : model
    bit    do_pop, do_push;
    ment_t e;
    if (rst) begin
      q.delete();
      mpc      = align(RPC);
      mfault   = 1'b0;
      model_ok = 1'b1;
    end else if (redirect_valid) begin
      q.delete();
      mpc    = align(redirect_pc);
      mfault = 1'b0;
    end else begin
      do_pop  = (q.size() > 0) && if_ready;
      do_push = !mfault && ((q.size() < DEPTH) || do_pop);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc    = mpc;
        e.instr = imem_word(mpc);
        e.fault = TRAP && (mpc[1:0] != 2'b00);
        q.push_back(e);
        if (e.fault) mfault = 1'b1;
        mpc = mpc + 32'd4;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_imem_addr", imem_addr, mpc);
      chk("m_if_valid", {31'd0, if_valid}, {31'd0, q.size() > 0});
      if (q.size() > 0) begin
        chk("m_if_pc", if_pc, q[0].pc);
        chk("m_if_instr", if_instr, q[0].instr);
        chk("m_if_fault", {31'd0, if_fault}, {31'd0, q[0].fault});
      end
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] pat;
    pat            = 16'b1011_0010_1110_0110;
    rst            = 1'b1;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    cyc(2);

    // Reset state
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_fault", {31'd0, if_fault}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);

    // 1: streaming with decode always ready
    rst = 1'b0; if_ready = 1'b1;
    cyc();
    chk("t1_valid", {31'd0, if_valid}, 32'd1);
    chk("t1_pc0", if_pc, 32'd0);
    chk("t1_instr0", if_instr, 32'h0000_0013);
    cyc();
    chk("t1_pc4", if_pc, 32'd4);
    chk("t1_instr4", if_instr, 32'h0010_0093);
    cyc();
    chk("t1_pc8", if_pc, 32'd8);

    // 2: stall fills the FIFO, then release with no gap
    do_reset();
    if_ready = 1'b0;
    cyc(5);
    chk("t2_hold_pc", if_pc, 32'd0);
    chk("t2_hold_addr", imem_addr, 32'd8);
    if_ready = 1'b1;
    cyc();
    chk("t2_rel_pc4", if_pc, 32'd4);
    cyc();
    chk("t2_rel_pc8", if_pc, 32'd8);

    // 3: redirect while head pc=4 is being accepted
    do_reset();
    if_ready = 1'b1;
    cyc(2);
    chk("t3_head4", if_pc, 32'd4);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    cyc();
    redirect_valid = 1'b0;
    chk("t3_flushed", {31'd0, if_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h100);
    cyc();
    chk("t3_pc100", if_pc, 32'h100);
    cyc();
    chk("t3_pc104", if_pc, 32'h104);

    // 4: wrap past 2^32
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t4_pcF8", if_pc, 32'hFFFF_FFF8);
    cyc();
    chk("t4_pcFC", if_pc, 32'hFFFF_FFFC);
    cyc();
    chk("t4_pc0", if_pc, 32'h0);

    // Back-to-back redirects: last target wins
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    cyc();
    redirect_pc = 32'h400;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("rr_last_wins", if_pc, 32'h400);

    // 5: misaligned redirect target
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    cyc();
    redirect_valid = 1'b0;
    cyc();
`ifdef IFU_MISALIGN_TRAP_EN
    chk("t5_valid", {31'd0, if_valid}, 32'd1);
    chk("t5_fault", {31'd0, if_fault}, 32'd1);
    chk("t5_pc", if_pc, 32'h102);
    cyc(3);
    chk("t5_no_push", {31'd0, if_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc();
    redirect_valid = 1'b0;
    cyc();
    chk("t5_recover_pc", if_pc, 32'h200);
    chk("t5_recover_fault", {31'd0, if_fault}, 32'd0);
`else
    chk("t5_aligned_pc", if_pc, 32'h100);
    chk("t5_no_fault", {31'd0, if_fault}, 32'd0);
    cyc();
    chk("t5_next_pc", if_pc, 32'h104);
`endif

    // Irregular ready pattern with a redirect mid-stream; model does the checking
    for (int i = 0; i < 40; i++) begin
      if_ready       = pat[i % 16];
      redirect_valid = (i == 20);
      redirect_pc    = 32'h40;
      cyc();
    end
    redirect_valid = 1'b0;

    // 6: reset dominates a full FIFO plus redirect
    do_reset();
    if_ready = 1'b0;
    cyc(3);
    chk("t6_full_addr", imem_addr, 32'd8);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500; if_ready = 1'b1;
    cyc();
    chk("t6_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_addr", imem_addr, RPC);
    rst = 1'b0; redirect_valid = 1'b0;
    cyc();
    chk("t6_restart_pc", if_pc, RPC);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
